// File: rtl/cla64_sub_pipe.sv
// cla64_sub_pipe
//   Two-stage pipelined 64-bit subtractor, diff = a - b - bin (mod 2^64),
//   computed as a + ~b + ~bin with 4-bit carry-lookahead groups.
//   Stage 1 produces the low 32 bits and the carry into bit 32.
//   Stage 2 produces the high 32 bits and the flags.
//   A valid/ready handshake sits on both sides; two beats at most are in flight.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   block accepts a beat this cycle
//   a, b, bin  minuend, subtrahend, borrow in
//   out_valid  result valid
//   out_ready  consumer accepts a result this cycle
//   diff       a - b - bin (saturated when CLA64_SUB_SAT_EN is defined)
//   bout       unsigned borrow out
//   zero       diff == 0, taken from the value driven on diff
//   ovf        signed overflow of the unsaturated result
//
// Build option
//   CLA64_SUB_SAT_EN  defined: clamp diff on signed overflow; undefined: wrap.
module cla64_sub_pipe (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] diff,
  output logic        bout,
  output logic        zero,
  output logic        ovf
);

  // Carries c0..c4 of a 4-wide generate/propagate slice, flat two-level form.
  function automatic logic [4:0] la4(input logic [3:0] g, input logic [3:0] p,
                                     input logic c);
    logic [4:0] r;
    r[0] = c;
    r[1] = g[0] | (p[0] & c);
    r[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    r[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    r[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c);
    return r;
  endfunction

  // 32-bit lookahead adder: 8 groups of 4 bits, 2 super-groups of 4 groups.
  // Returns {carry_out, sum}.
  function automatic logic [32:0] cla32(input logic [31:0] x, input logic [31:0] y,
                                        input logic cin);
    logic [31:0] g, p, c;
    logic [7:0]  gg, gp, gc;
    logic [1:0]  sg, sp;
    logic [4:0]  t, sc;
    g = x & y;
    p = x ^ y;
    for (int k = 0; k < 8; k++) begin
      t     = la4(g[4*k +: 4], p[4*k +: 4], 1'b0);
      gg[k] = t[4];
      gp[k] = &p[4*k +: 4];
    end
    for (int s = 0; s < 2; s++) begin
      t     = la4(gg[4*s +: 4], gp[4*s +: 4], 1'b0);
      sg[s] = t[4];
      sp[s] = &gp[4*s +: 4];
    end
    // sc[0] = cin, sc[1] = carry into group 4, sc[2] = carry out of bit 31
    sc = la4({2'b00, sg}, {2'b00, sp}, cin);
    for (int s = 0; s < 2; s++) begin
      t = la4(gg[4*s +: 4], gp[4*s +: 4], sc[s]);
      gc[4*s +: 4] = t[3:0];
    end
    for (int k = 0; k < 8; k++) begin
      t = la4(g[4*k +: 4], p[4*k +: 4], gc[k]);
      c[4*k +: 4] = t[3:0];
    end
    return {sc[2], p ^ c};
  endfunction

  logic        v1, v2;
  logic        load2, adv1;
  logic [31:0] lo_q, ahi_q, nbhi_q;
  logic        c32_q, a63_q, b63_q;
  logic [32:0] lo_sum, hi_sum;
  logic [63:0] raw, diff_n;
  logic        ovf_n, bout_n;

  assign load2     = !v2 || out_ready;
  assign adv1      = !v1 || load2;
  assign in_ready  = adv1;
  assign out_valid = v2;

  always_comb begin
    lo_sum = cla32(a[31:0], ~b[31:0], ~bin);
    hi_sum = cla32(ahi_q, nbhi_q, c32_q);
  end

  assign raw    = {hi_sum[31:0], lo_q};
  assign bout_n = ~hi_sum[32];
  assign ovf_n  = (a63_q ^ b63_q) & (raw[63] ^ a63_q);

`ifdef CLA64_SUB_SAT_EN
  // Clamp toward the sign of the minuend: positive a saturates high.
  assign diff_n = !ovf_n ? raw :
                  (a63_q ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF);
`else
  assign diff_n = raw;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      v1     <= 1'b0;
      lo_q   <= '0;
      ahi_q  <= '0;
      nbhi_q <= '0;
      c32_q  <= 1'b0;
      a63_q  <= 1'b0;
      b63_q  <= 1'b0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        lo_q   <= lo_sum[31:0];
        c32_q  <= lo_sum[32];
        ahi_q  <= a[63:32];
        nbhi_q <= ~b[63:32];
        a63_q  <= a[63];
        b63_q  <= b[63];
      end
    end
  end

  // Output registers only change on a real load so a stalled result stays put.
  always_ff @(posedge clk) begin
    if (reset) begin
      v2   <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
      zero <= 1'b0;
      ovf  <= 1'b0;
    end else if (load2) begin
      v2 <= v1;
      if (v1) begin
        diff <= diff_n;
        bout <= bout_n;
        zero <= (diff_n == 64'd0);
        ovf  <= ovf_n;
      end
    end
  end

endmodule

// File: tb/tb_cla64_sub_pipe.sv
module tb_cla64_sub_pipe;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic [63:0] d;
    logic        bo;
    logic        z;
    logic        o;
  } vec_t;

  localparam int NV = 12;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a, b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] diff;
  logic        bout, zero, ovf;

  vec_t tbl [NV];
  int   q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   first_acc, first_con, last_con, ncon;

  cla64_sub_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, observe handshakes before the rising edge.
  task automatic tick(input logic iv, input int idx, input logic ordy, output logic acc);
    int h;
    @(negedge clk);
    in_valid  = iv;
    a         = tbl[idx].a;
    b         = tbl[idx].b;
    bin       = tbl[idx].bin;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_result", {63'd0, out_valid}, 64'd0);
      end else begin
        h = q.pop_front();
        chk($sformatf("diff[%0d]", h), diff, tbl[h].d);
        chk($sformatf("bout[%0d]", h), {63'd0, bout}, {63'd0, tbl[h].bo});
        chk($sformatf("zero[%0d]", h), {63'd0, zero}, {63'd0, tbl[h].z});
        chk($sformatf("ovf[%0d]", h), {63'd0, ovf}, {63'd0, tbl[h].o});
      end
      if (first_con < 0) first_con = cyc;
      last_con = cyc;
      ncon++;
    end
    acc = in_valid && in_ready && !reset;
    if (acc) begin
      q.push_back(idx);
      if (first_acc < 0) first_acc = cyc;
    end
    cyc++;
  endtask

  initial begin
    logic acc, got;
    int   n;
    logic [63:0] hd;
    logic hb, hz, ho;

    //            a                        b                      bin  diff                     bout zero ovf
    tbl[0]  = '{64'd5,                  64'd3,                  1'b0, 64'd2,                  1'b0, 1'b0, 1'b0};
    tbl[1]  = '{64'd0,                  64'd1,                  1'b0, ONES,                   1'b1, 1'b0, 1'b0};
`ifdef CLA64_SUB_SAT_EN
    tbl[2]  = '{MINN,                   64'd1,                  1'b0, MINN,                   1'b0, 1'b0, 1'b1};
    tbl[5]  = '{MAXP,                   ONES,                   1'b0, MAXP,                   1'b1, 1'b0, 1'b1};
    tbl[10] = '{64'd0,                  MINN,                   1'b0, MAXP,                   1'b1, 1'b0, 1'b1};
`else
    tbl[2]  = '{MINN,                   64'd1,                  1'b0, MAXP,                   1'b0, 1'b0, 1'b1};
    tbl[5]  = '{MAXP,                   ONES,                   1'b0, MINN,                   1'b1, 1'b0, 1'b1};
    tbl[10] = '{64'd0,                  MINN,                   1'b0, MINN,                   1'b1, 1'b0, 1'b1};
`endif
    tbl[3]  = '{64'h1234,               64'h1234,               1'b0, 64'd0,                  1'b0, 1'b1, 1'b0};
    tbl[4]  = '{64'h1234,               64'h1234,               1'b1, ONES,                   1'b1, 1'b0, 1'b0};
    tbl[6]  = '{64'h1_0000_0000,        64'd1,                  1'b0, 64'hFFFF_FFFF,          1'b0, 1'b0, 1'b0};
    tbl[7]  = '{64'd0,                  64'd0,                  1'b1, ONES,                   1'b1, 1'b0, 1'b0};
    tbl[8]  = '{ONES,                   ONES,                   1'b1, ONES,                   1'b1, 1'b0, 1'b0};
    tbl[9]  = '{64'h0123_4567_89AB_CDEF, 64'h0011_1111_1111_1111, 1'b0, 64'h0112_3456_789A_BCDE, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{MINN,                   MINN,                   1'b1, ONES,                   1'b1, 1'b0, 1'b0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_diff", diff, 64'd0);
    chk("rst_flags", {61'd0, bout, zero, ovf}, 64'd0);

    // Back-to-back stream through the whole table with the consumer always ready.
    first_acc = -1; first_con = -1; last_con = -1; ncon = 0;
    for (int i = 0; i < NV; i++) begin
      tick(1'b1, i, 1'b1, acc);
      chk($sformatf("stream_accept[%0d]", i), {63'd0, acc}, 64'd1);
    end
    n = 0;
    while (q.size() > 0 && n < 10) begin
      tick(1'b0, 0, 1'b1, acc);
      n++;
    end
    chk("stream_drained", 64'(q.size()), 64'd0);
    chk("stream_count", 64'(ncon), 64'(NV));
    chk("latency", 64'(first_con - first_acc), 64'd2);
    chk("throughput_span", 64'(last_con - first_acc), 64'(NV + 1));

    // Stall: three beats offered while the consumer holds off for four cycles.
    ncon = 0;
    tick(1'b1, 0, 1'b0, acc);
    chk("stall_acc_a", {63'd0, acc}, 64'd1);
    tick(1'b1, 1, 1'b0, acc);
    chk("stall_acc_b", {63'd0, acc}, 64'd1);
    tick(1'b1, 9, 1'b0, acc);
    chk("stall_in_ready_low", {63'd0, in_ready}, 64'd0);
    chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
    hd = diff; hb = bout; hz = zero; ho = ovf;
    chk("stall_head_diff", hd, tbl[0].d);
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 9, 1'b0, acc);
      chk($sformatf("stall_hold_diff[%0d]", k), diff, hd);
      chk($sformatf("stall_hold_flags[%0d]", k), {61'd0, bout, zero, ovf}, {61'd0, hb, hz, ho});
      chk($sformatf("stall_no_accept[%0d]", k), {63'd0, acc}, 64'd0);
    end
    got = 1'b0; n = 0;
    while (!got && n < 10) begin
      tick(1'b1, 9, 1'b1, acc);
      got = acc;
      n++;
    end
    chk("stall_acc_c", {63'd0, got}, 64'd1);
    n = 0;
    while (q.size() > 0 && n < 10) begin
      tick(1'b0, 0, 1'b1, acc);
      n++;
    end
    chk("stall_drained", 64'(q.size()), 64'd0);
    chk("stall_count", 64'(ncon), 64'd3);

    // Reset with both stages full, a beat presented during reset.
    tick(1'b1, 3, 1'b0, acc);
    tick(1'b1, 4, 1'b0, acc);
    tick(1'b0, 0, 1'b0, acc);
    chk("pre_reset_full", {62'd0, out_valid, in_ready}, 64'd2);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; a = tbl[5].a; b = tbl[5].b; bin = tbl[5].bin;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    q.delete();
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("mid_rst_diff", diff, 64'd0);
    ncon = 0;
    for (int k = 0; k < 6; k++) tick(1'b0, 0, 1'b1, acc);
    chk("no_stale_after_reset", 64'(ncon), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
